// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// Optional feature: define ALU_ARB_MUL_STALL_EN to hold EXEC for MUL_LATENCY cycles on MUL.
module alu_arbiter #(
    parameter int MUL_LATENCY = 3
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        req0Valid,
    output logic        req0Ready,
    input  logic [31:0] req0Operand1,
    input  logic [31:0] req0Operand2,
    input  logic [2:0]  req0Op,
    input  logic        req1Valid,
    output logic        req1Ready,
    input  logic [31:0] req1Operand1,
    input  logic [31:0] req1Operand2,
    input  logic [2:0]  req1Op,
    output logic        resp0Valid,
    output logic [7:0]  resp0Result,
    output logic        resp0Zero,
    output logic        resp1Valid,
    output logic [7:0]  resp1Result,
    output logic        resp1Zero,
    output logic [31:0] aluOperand1,
    output logic [31:0] aluOperand2,
    output logic [2:0]  aluOp,
    input  logic [7:0]  aluResult,
    input  logic        aluZero,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    localparam logic [2:0] OP_MUL = 3'b100;

    if (MUL_LATENCY < 1 || MUL_LATENCY > 15) begin : g_bad_latency
        $error("alu_arbiter: MUL_LATENCY must be in 1..15");
    end

    state_t      state;
    logic        last_grant;   // 1 = port 1 was served last
    logic        port_q;
    logic        illegal_q;
    logic        grant0;
    logic        grant1;
    logic        accept;
    logic [31:0] sel_op1;
    logic [31:0] sel_op2;
    logic [2:0]  sel_op;
    logic        sel_illegal;
    logic        exec_done;

`ifdef ALU_ARB_MUL_STALL_EN
    logic [3:0]  dwell;
`endif

    always_comb begin
        grant0      = req0Valid && (!req1Valid || last_grant);
        grant1      = req1Valid && (!req0Valid || !last_grant);
        accept      = (state == IDLE) && (grant0 || grant1);
        req0Ready   = resetN && (state == IDLE) && grant0;
        req1Ready   = resetN && (state == IDLE) && grant1;
        sel_op1     = grant1 ? req1Operand1 : req0Operand1;
        sel_op2     = grant1 ? req1Operand2 : req0Operand2;
        sel_op      = grant1 ? req1Op : req0Op;
        sel_illegal = (sel_op[2:1] == 2'b11);
`ifdef ALU_ARB_MUL_STALL_EN
        exec_done   = (dwell == 4'd0);
`else
        exec_done   = 1'b1;
`endif
    end

    always_ff @(posedge clk) begin
        if (!resetN) begin
            state       <= IDLE;
            last_grant  <= 1'b1;
            port_q      <= 1'b0;
            illegal_q   <= 1'b0;
            resp0Valid  <= 1'b0;
            resp0Result <= '0;
            resp0Zero   <= 1'b0;
            resp1Valid  <= 1'b0;
            resp1Result <= '0;
            resp1Zero   <= 1'b0;
            aluOperand1 <= '0;
            aluOperand2 <= '0;
            aluOp       <= '0;
            busy        <= 1'b0;
`ifdef ALU_ARB_MUL_STALL_EN
            dwell       <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        port_q    <= grant1;
                        illegal_q <= sel_illegal;
                        busy      <= 1'b1;
                        state     <= EXEC;
                        // Illegal ops are accepted but never reach the ALU.
                        if (!sel_illegal) begin
                            aluOperand1 <= sel_op1;
                            aluOperand2 <= sel_op2;
                            aluOp       <= sel_op;
                        end
`ifdef ALU_ARB_MUL_STALL_EN
                        dwell <= (sel_op == OP_MUL) ? 4'(MUL_LATENCY - 1) : '0;
`endif
                    end
                end
                EXEC: begin
                    if (exec_done) begin
                        aluOperand1 <= '0;
                        aluOperand2 <= '0;
                        aluOp       <= '0;
                        state       <= RESP;
                        if (port_q) begin
                            resp1Valid  <= 1'b1;
                            resp1Result <= illegal_q ? 8'h00 : aluResult;
                            resp1Zero   <= illegal_q ? 1'b1 : aluZero;
                        end else begin
                            resp0Valid  <= 1'b1;
                            resp0Result <= illegal_q ? 8'h00 : aluResult;
                            resp0Zero   <= illegal_q ? 1'b1 : aluZero;
                        end
                    end
`ifdef ALU_ARB_MUL_STALL_EN
                    else begin
                        dwell <= dwell - 4'd1;
                    end
`endif
                end
                RESP: begin
                    resp0Valid <= 1'b0;
                    resp1Valid <= 1'b0;
                    last_grant <= port_q;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed, table-driven bench for alu_arbiter with a small behavioural ALU attached.
module tb_alu_arbiter;

    localparam int MUL_LAT = 3;
`ifdef ALU_ARB_MUL_STALL_EN
    localparam int EXP_MUL_DWELL = MUL_LAT;
`else
    localparam int EXP_MUL_DWELL = 1;
`endif

    logic        clk = 1'b0;
    logic        resetN;
    logic        req0Valid, req1Valid;
    logic        req0Ready, req1Ready;
    logic [31:0] req0Operand1, req0Operand2, req1Operand1, req1Operand2;
    logic [2:0]  req0Op, req1Op;
    logic        resp0Valid, resp1Valid;
    logic [7:0]  resp0Result, resp1Result;
    logic        resp0Zero, resp1Zero;
    logic [31:0] aluOperand1, aluOperand2;
    logic [2:0]  aluOp;
    logic [7:0]  aluResult;
    logic        aluZero;
    logic        busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.MUL_LATENCY(MUL_LAT)) dut (
        .clk(clk), .resetN(resetN),
        .req0Valid(req0Valid), .req0Ready(req0Ready),
        .req0Operand1(req0Operand1), .req0Operand2(req0Operand2), .req0Op(req0Op),
        .req1Valid(req1Valid), .req1Ready(req1Ready),
        .req1Operand1(req1Operand1), .req1Operand2(req1Operand2), .req1Op(req1Op),
        .resp0Valid(resp0Valid), .resp0Result(resp0Result), .resp0Zero(resp0Zero),
        .resp1Valid(resp1Valid), .resp1Result(resp1Result), .resp1Zero(resp1Zero),
        .aluOperand1(aluOperand1), .aluOperand2(aluOperand2), .aluOp(aluOp),
        .aluResult(aluResult), .aluZero(aluZero), .busy(busy)
    );

    // Behavioural ALU: 8-bit result, zero flag on the 8-bit result.
    logic [31:0] alu_full;
    always_comb begin
        alu_full = '0;
        case (aluOp)
            3'b000: alu_full = aluOperand1 + aluOperand2;
            3'b001: alu_full = aluOperand1 - aluOperand2;
            3'b010: alu_full = aluOperand1 & aluOperand2;
            3'b011: alu_full = aluOperand1 | aluOperand2;
            3'b100: alu_full = aluOperand1 * aluOperand2;
            3'b101: alu_full = aluOperand1 << aluOperand2[4:0];
            default: alu_full = '0;
        endcase
        aluResult = alu_full[7:0];
        aluZero   = (alu_full[7:0] == 8'h00);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        port;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [7:0]  res;
        logic        zero;
        logic        illegal;
        int          dwell;
    } vec_t;

    task automatic drive(input logic port, input logic valid, input logic [2:0] op,
                         input logic [31:0] a, input logic [31:0] b);
        if (port) begin
            req1Valid = valid; req1Op = op; req1Operand1 = a; req1Operand2 = b;
        end else begin
            req0Valid = valid; req0Op = op; req0Operand1 = a; req0Operand2 = b;
        end
    endtask

    // Entered and left at a negedge with the arbiter idle.
    task automatic run_vec(input vec_t v, input int idx);
        string tag;
        tag = $sformatf("v%0d", idx);
        drive(v.port, 1'b1, v.op, v.a, v.b);
        #1;
        chk({tag, "_ready_own"}, v.port ? req1Ready : req0Ready, 1'b1);
        chk({tag, "_ready_other"}, v.port ? req0Ready : req1Ready, 1'b0);
        @(posedge clk);
        @(negedge clk);
        drive(v.port, 1'b0, 3'b000, '0, '0);
        for (int i = 0; i < v.dwell; i++) begin
            #1;
            chk({tag, "_alu_op"}, aluOp, v.illegal ? 3'b000 : v.op);
            chk({tag, "_alu_a"}, aluOperand1, v.illegal ? 32'h0 : v.a);
            chk({tag, "_alu_b"}, aluOperand2, v.illegal ? 32'h0 : v.b);
            chk({tag, "_busy_exec"}, busy, 1'b1);
            chk({tag, "_no_early_resp"}, resp0Valid | resp1Valid, 1'b0);
            @(negedge clk);
        end
        #1;
        chk({tag, "_resp_own"}, v.port ? resp1Valid : resp0Valid, 1'b1);
        chk({tag, "_resp_other"}, v.port ? resp0Valid : resp1Valid, 1'b0);
        chk({tag, "_result"}, v.port ? resp1Result : resp0Result, v.res);
        chk({tag, "_zero"}, v.port ? resp1Zero : resp0Zero, v.zero);
        chk({tag, "_alu_idle_resp"}, aluOp, 3'b000);
        @(negedge clk);
        #1;
        chk({tag, "_resp_drop"}, resp0Valid | resp1Valid, 1'b0);
        chk({tag, "_busy_idle"}, busy, 1'b0);
        // Result holds between pulses.
        chk({tag, "_result_hold"}, v.port ? resp1Result : resp0Result, v.res);
    endtask

    vec_t vecs[9];

    initial begin
        vecs[0] = '{1'b1, 3'b000, 32'd5,    32'd7,    8'h0C, 1'b0, 1'b0, 1};
        vecs[1] = '{1'b0, 3'b001, 32'd9,    32'd9,    8'h00, 1'b1, 1'b0, 1};
        vecs[2] = '{1'b0, 3'b010, 32'hF0,   32'h3C,   8'h30, 1'b0, 1'b0, 1};
        vecs[3] = '{1'b1, 3'b011, 32'h0F,   32'hF0,   8'hFF, 1'b0, 1'b0, 1};
        vecs[4] = '{1'b0, 3'b100, 32'd3,    32'd4,    8'h0C, 1'b0, 1'b0, EXP_MUL_DWELL};
        vecs[5] = '{1'b1, 3'b101, 32'd1,    32'd7,    8'h80, 1'b0, 1'b0, 1};
        vecs[6] = '{1'b1, 3'b110, 32'd8,    32'd2,    8'h00, 1'b1, 1'b1, 1};
        vecs[7] = '{1'b0, 3'b111, 32'd5,    32'd7,    8'h00, 1'b1, 1'b1, 1};
        vecs[8] = '{1'b0, 3'b000, 32'hFF,   32'd1,    8'h00, 1'b1, 1'b0, 1};

        // Reset with both requesters asserting SUB 9-9.
        resetN = 1'b0;
        drive(1'b0, 1'b1, 3'b001, 32'd9, 32'd9);
        drive(1'b1, 1'b1, 3'b001, 32'd9, 32'd9);
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_ready0", req0Ready, 1'b0);
        chk("rst_ready1", req1Ready, 1'b0);
        chk("rst_resp_valid", {resp0Valid, resp1Valid}, 2'b00);
        chk("rst_results", {resp0Result, resp1Result}, 16'h0000);
        chk("rst_zero", {resp0Zero, resp1Zero}, 2'b00);
        chk("rst_alu", {aluOperand1, aluOperand2, aluOp} == '0, 1'b1);
        chk("rst_busy", busy, 1'b0);

        // Release: round-robin with both ports held valid, 4 grants.
        resetN = 1'b1;
        for (int k = 0; k < 12; k++) begin
            #1;
            chk($sformatf("rr%0d_ready0", k), req0Ready, (k % 3 == 0) && ((k / 3) % 2 == 0));
            chk($sformatf("rr%0d_ready1", k), req1Ready, (k % 3 == 0) && ((k / 3) % 2 == 1));
            chk($sformatf("rr%0d_resp0", k), resp0Valid, (k % 3 == 2) && ((k / 3) % 2 == 0));
            chk($sformatf("rr%0d_resp1", k), resp1Valid, (k % 3 == 2) && ((k / 3) % 2 == 1));
            if (k % 3 == 1)
                chk($sformatf("rr%0d_alu_op", k), aluOp, 3'b001);
            if (k % 3 == 2) begin
                chk($sformatf("rr%0d_result", k), ((k / 3) % 2 == 1) ? resp1Result : resp0Result, 8'h00);
                chk($sformatf("rr%0d_zero", k), ((k / 3) % 2 == 1) ? resp1Zero : resp0Zero, 1'b1);
            end
            if (k == 11) begin
                drive(1'b0, 1'b0, 3'b000, '0, '0);
                drive(1'b1, 1'b0, 3'b000, '0, '0);
            end
            @(negedge clk);
        end

        for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

        // Reset mid-EXEC: last served was port 0, so without reset the tie would go to port 1.
        @(negedge clk);
        drive(1'b1, 1'b1, 3'b000, 32'd5, 32'd7);
        #1;
        chk("mid_ready1", req1Ready, 1'b1);
        @(posedge clk);
        @(negedge clk);
        drive(1'b1, 1'b0, 3'b000, '0, '0);
        #1;
        chk("mid_busy", busy, 1'b1);
        resetN = 1'b0;
        @(negedge clk);
        drive(1'b0, 1'b1, 3'b001, 32'd9, 32'd9);
        drive(1'b1, 1'b1, 3'b001, 32'd9, 32'd9);
        #1;
        chk("mid_no_resp", {resp0Valid, resp1Valid}, 2'b00);
        chk("mid_busy_clr", busy, 1'b0);
        chk("mid_alu_idle", aluOp, 3'b000);
        chk("mid_ready_in_rst", {req0Ready, req1Ready}, 2'b00);
        resetN = 1'b1;
        #1;
        chk("mid_tie_ready0", req0Ready, 1'b1);
        chk("mid_tie_ready1", req1Ready, 1'b0);
        @(posedge clk);
        @(negedge clk);
        drive(1'b0, 1'b0, 3'b000, '0, '0);
        drive(1'b1, 1'b0, 3'b000, '0, '0);
        #1;
        chk("mid_no_resp_t1", {resp0Valid, resp1Valid}, 2'b00);
        @(negedge clk);
        #1;
        chk("mid_after_resp0", {resp0Valid, resp1Valid}, 2'b10);
        chk("mid_after_zero", resp0Zero, 1'b1);
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single combinational ALU between two requesters, the integer execute path (port 0) and the address/branch helper path (port 1). It accepts operations over a valid/ready handshake, registers operands, drives the ALU, captures its 8-bit result and zero flag, and returns them as a one-cycle response pulse to the issuing requester. Arbitration is round-robin. One operation is in flight at a time.

## Interface
Parameters:
- MUL_LATENCY, 3, cycles the ALU is held for a MUL (3'b100) when ALU_ARB_MUL_STALL_EN is defined; legal range 1..15.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- resetN  in  1  reset; one clock, synchronous, active-low.
- req0Valid / req1Valid  in  1  request present.
- req0Ready / req1Ready  out  1  request accepted this cycle.
- req0Operand1 / req1Operand1  in  32  first operand.
- req0Operand2 / req1Operand2  in  32  second operand.
- req0Op / req1Op  in  3  ALU opcode: ADD 000, SUB 001, AND 010, OR 011, MUL 100, SLL 101.
- resp0Valid / resp1Valid  out  1  one-cycle response pulse.
- resp0Result / resp1Result  out  8  captured ALU result.
- resp0Zero / resp1Zero  out  1  captured zero flag.
- aluOperand1  out  32  to ALU operand1.
- aluOperand2  out  32  to ALU operand2.
- aluOp  out  3  to ALU opcode.
- aluResult  in  8  from ALU.
- aluZero  in  1  from ALU.
- busy  out  1  high in EXEC and RESP.

## Operation
- States: IDLE, EXEC, RESP. Reset → IDLE.
- IDLE: grant selection is combinational. Only one valid: that port is granted. Both valid: the port not granted last is granted. reqNReady = (state==IDLE) && granted. On valid&&ready, register operands, opcode, and port ID. Go to EXEC.
- EXEC: drive aluOperand1/2/aluOp from the registers. After the EXEC dwell ends, register aluResult and aluZero into the response registers. Go to RESP.
- RESP: respNValid=1 for the stored port only. Update lastGrant to that port. Go to IDLE.
- Illegal opcode (110, 111): the request is accepted but not issued. The ALU outputs stay at idle values, and the response returns result 8'h00 with zero=1 after the normal non-MUL latency.
- Idle ALU drive (IDLE, RESP, illegal op): aluOperand1=0, aluOperand2=0, aluOp=000.
- respNResult/respNZero hold their last captured value between pulses. They are only meaningful while respNValid is high.
- Results are 8 bits as produced by the ALU; the arbiter does no width conversion.

## Timing
- Reset values: req0Ready=req1Ready=0 while resetN low, resp*Valid=0, resp*Result=8'h00, resp*Zero=0, aluOperand1/2=0, aluOp=000, busy=0. lastGrant=port 1, so port 0 wins the first tie.
- Handshake in cycle T (non-MUL, or macro undefined): EXEC in T+1, capture at end of T+1, respValid in T+2, IDLE in T+3. Next accept at T+3 at the earliest. Sustained throughput is 1 op per 3 cycles.
- MUL with macro defined: EXEC dwells MUL_LATENCY cycles. Capture at end of the last EXEC cycle; respValid in T+1+MUL_LATENCY.
- Ready depends combinationally on valids and may not be used to form valid. A requester holds valid and its operands stable until ready.
- reqValid dropped before ready: nothing is issued.
- resetN low in any state: return to IDLE next edge. The in-flight op is discarded, no response is produced, and lastGrant resets.

## Configuration
- ALU_ARB_MUL_STALL_EN defined: MUL holds EXEC for MUL_LATENCY cycles, with an internal 4-bit dwell counter loaded at accept. This allows a multicycle-path MUL timing constraint.
- Undefined: every opcode dwells exactly one EXEC cycle; no counter is built, and MUL_LATENCY is ignored.

## Test plan
- Reset: hold resetN=0 for 2 cycles with both valids high → all outputs at reset values, no ready. First cycle after release: req0Ready=1, req1Ready=0.
- Single ADD on port 1: 5 + 7, valid at T → req1Ready at T, aluOp=000 and operands 5/7 in T+1, resp1Valid at T+2 with result 8'h0C and zero=0; resp0Valid stays 0.
- Round-robin: both ports hold SUB 9−9 continuously → grants alternate 0,1,0,1 every 3 cycles. Each response gives result 0 with zero=1.
- MUL 3×4 with macro defined and MUL_LATENCY=3: accept at T → aluOp=100 for T+1..T+3, resp0Valid at T+4 with result 8'h0C. With macro undefined: respValid at T+2.
- Illegal op 3'b111 on port 0 → aluOp stays 000 with zero operands, and resp0Valid at T+2 with result 8'h00, zero=1.
- Reset mid-EXEC: pull resetN low in T+1 → no response pulse, IDLE next cycle, and the next tie is granted to port 0.
